// File: rtl/score_pkg.sv
// Shared constants, FSM state encodings and the saturating adder used by the
// score table engine and its compare/accumulate stage.
package score_pkg;

  localparam int DEF_NUM_PLAYERS = 16;
  localparam int DEF_ID_W        = 16;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_SCORE_W     = 16;
  localparam int DEF_TOTAL_W     = 24;
  localparam int DEF_RAM_LAT     = 2;

  localparam logic [2:0] S_CLEAR    = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_UPD_RD   = 3'd2;
  localparam logic [2:0] S_UPD_WAIT = 3'd3;
  localparam logic [2:0] S_UPD_WR   = 3'd4;
  localparam logic [2:0] S_SCAN     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  // Unsigned a+b clamped to 2**w-1; a carry out of bit w-1 forces all-ones.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/score_max_acc.sv
// Scan-side compare/accumulate stage: tracks the highest score (lowest id on
// ties) and the saturated running total of every valid entry presented.
module score_max_acc
  import score_pkg::*;
#(
  parameter int ID_W    = DEF_ID_W,
  parameter int SCORE_W = DEF_SCORE_W,
  parameter int TOTAL_W = DEF_TOTAL_W
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [ID_W-1:0]    i_id,
  input  logic [SCORE_W-1:0] i_score,
  output logic [ID_W-1:0]    o_best_id,
  output logic [SCORE_W-1:0] o_best_score,
  output logic [TOTAL_W-1:0] o_total
);

  logic [ID_W-1:0]    r_best_id;
  logic [SCORE_W-1:0] r_best_score;
  logic [TOTAL_W-1:0] r_total;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_best_id    <= '0;
      r_best_score <= '0;
      r_total      <= '0;
    end else if (i_valid) begin
      // Strictly greater only, so the first (lowest) id wins a tie.
      if (i_score > r_best_score) begin
        r_best_id    <= i_id;
        r_best_score <= i_score;
      end
      r_total <= TOTAL_W'(sat_add(32'(r_total), 32'(i_score), TOTAL_W));
    end
  end

  assign o_best_id    = r_best_id;
  assign o_best_score = r_best_score;
  assign o_total      = r_total;

endmodule

// File: rtl/score_table_engine.sv
// Score table engine: clears the score RAM after reset, serialises saturating
// read-modify-write updates and runs a pipelined full-table report scan.
module score_table_engine
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int ID_W        = DEF_ID_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int TOTAL_W     = DEF_TOTAL_W,
  parameter int RAM_LAT     = DEF_RAM_LAT
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [ID_W-1:0]    upd_id,
  input  logic [SCORE_W-1:0] upd_points,
  output logic               upd_err,
  input  logic               rpt_start,
  output logic               rpt_busy,
  output logic               rpt_valid,
  output logic [ID_W-1:0]    rpt_id,
  output logic [SCORE_W-1:0] rpt_score,
  output logic [TOTAL_W-1:0] rpt_total,
  output logic               init_done,
  output logic               ram_wren,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [SCORE_W-1:0] ram_wdata,
  input  logic [SCORE_W-1:0] ram_rdata,
  output logic [2:0]         dbg_state
);

  localparam int CW = ADDR_W + 2;
  localparam logic [CW-1:0] C_N   = CW'(NUM_PLAYERS);
  localparam logic [CW-1:0] C_CAP = CW'(RAM_LAT + 1);
  localparam logic [CW-1:0] C_FIN = CW'(NUM_PLAYERS + RAM_LAT + 1);
  localparam logic [31:0]   C_NP  = 32'(NUM_PLAYERS);

  logic [2:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [SCORE_W-1:0] r_points;
  logic               r_addr_v;
  logic [RAM_LAT-1:0] r_sr_v;
  logic [ADDR_W-1:0]  r_sr_id [RAM_LAT];
  logic               w_scan_start;
  logic [ID_W-1:0]    w_best_id;
  logic [SCORE_W-1:0] w_best_score;
  logic [TOTAL_W-1:0] w_total;

  // Update handshake: a request is taken on a clock edge where upd_valid and
  // the registered upd_ready are both high; the requester holds id/points
  // until then. A report start seen in IDLE wins over a same-cycle update.
  assign w_scan_start = (r_state == S_IDLE) && rpt_start;
  assign dbg_state    = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_points  <= '0;
      r_addr_v  <= 1'b0;
      upd_ready <= 1'b0;
      upd_err   <= 1'b0;
      rpt_busy  <= 1'b0;
      rpt_valid <= 1'b0;
      rpt_id    <= '0;
      rpt_score <= '0;
      rpt_total <= '0;
      init_done <= 1'b0;
      ram_wren  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      upd_err   <= 1'b0;
      rpt_valid <= 1'b0;
      ram_wren  <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (r_cnt == C_N) begin
            r_state   <= S_IDLE;
            init_done <= 1'b1;
            upd_ready <= 1'b1;
            rpt_busy  <= 1'b0;
          end else begin
            ram_wren  <= 1'b1;
            ram_addr  <= r_cnt[ADDR_W-1:0];
            ram_wdata <= '0;
            rpt_busy  <= 1'b1;
            r_cnt     <= r_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (w_scan_start) begin
            r_state   <= S_SCAN;
            upd_ready <= 1'b0;
            rpt_busy  <= 1'b1;
            ram_addr  <= '0;
            r_addr_v  <= 1'b1;
            r_cnt     <= CW'(1);
          end else if (upd_valid) begin
            r_points <= upd_points;
            if (32'(upd_id) >= C_NP) begin
              upd_err <= 1'b1;
            end else begin
              r_state   <= S_UPD_RD;
              upd_ready <= 1'b0;
              ram_addr  <= ADDR_W'(upd_id);
              r_cnt     <= CW'(1);
            end
          end
        end
        // r_cnt is the cycle number since acceptance; read data lands on C_CAP.
        S_UPD_RD, S_UPD_WAIT: begin
          if (r_cnt == C_CAP) begin
            r_state   <= S_UPD_WR;
            ram_wren  <= 1'b1;
            ram_wdata <= SCORE_W'(sat_add(32'(ram_rdata), 32'(r_points), SCORE_W));
          end else begin
            r_state <= S_UPD_WAIT;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_UPD_WR: begin
          r_state   <= S_IDLE;
          upd_ready <= 1'b1;
        end
        S_SCAN: begin
          if (r_cnt < C_N) ram_addr <= r_cnt[ADDR_W-1:0];
          else             r_addr_v <= 1'b0;
          if (r_cnt == C_FIN) begin
            r_state   <= S_DONE;
            rpt_valid <= 1'b1;
            rpt_busy  <= 1'b0;
            rpt_id    <= w_best_id;
            rpt_score <= w_best_score;
            rpt_total <= w_total;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          upd_ready <= 1'b1;
        end
        default: begin
          r_state <= S_CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Address/valid shadow of the RAM read pipeline, aligned with ram_rdata.
  always_ff @(posedge clk) begin
    if (rst) r_sr_v <= '0;
    else begin
      r_sr_v[0] <= r_addr_v;
      for (int i = 1; i < RAM_LAT; i++) r_sr_v[i] <= r_sr_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_sr_id[0] <= ram_addr;
    for (int i = 1; i < RAM_LAT; i++) r_sr_id[i] <= r_sr_id[i-1];
  end

  score_max_acc #(
    .ID_W    (ID_W),
    .SCORE_W (SCORE_W),
    .TOTAL_W (TOTAL_W)
  ) u_max_acc (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_scan_start),
    .i_valid      (r_sr_v[RAM_LAT-1]),
    .i_id         (ID_W'(r_sr_id[RAM_LAT-1])),
    .i_score      (ram_rdata),
    .o_best_id    (w_best_id),
    .o_best_score (w_best_score),
    .o_total      (w_total)
  );

endmodule
